// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit (radix-2 shift-add / restoring divide).
// Optional macro MULDIV_EARLY_OUT_EN: trivial cases (zero multiply, divide by zero, signed overflow) finish in one cycle.
module muldiv_unit #(
   parameter int DATA_W = 64,
   parameter int TAG_W  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        op,
   input  logic [DATA_W-1:0] operand_a,
   input  logic [DATA_W-1:0] operand_b,
   input  logic [TAG_W-1:0]  in_tag,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] result,
   output logic [TAG_W-1:0]  out_tag,
   output logic              busy
);

   localparam int CNT_W = $clog2(DATA_W) + 1;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [DATA_W-1:0]   acc;
   logic [DATA_W-1:0]   lo;
   logic [DATA_W-1:0]   opnd;
   logic [2:0]          op_q;
   logic [TAG_W-1:0]    tag_q;
   logic                neg_res;
   logic                neg_rem;
   logic                div_zero;

   logic                accept;
   logic                a_signed_in;
   logic                b_signed_in;
   logic                neg_a_in;
   logic                neg_b_in;
   logic [DATA_W-1:0]   a_mag_in;
   logic [DATA_W-1:0]   b_mag_in;
   logic [DATA_W:0]     mul_sum;
   logic [DATA_W:0]     div_shift;
   logic [DATA_W:0]     div_diff;
   logic                div_ge;
   logic [2*DATA_W-1:0] prod_fix;
   logic [DATA_W-1:0]   quo_fix;
   logic [DATA_W-1:0]   rem_fix;
   logic [DATA_W-1:0]   fix_result;
   logic                early;
   logic [DATA_W-1:0]   early_result;

   assign in_ready = (state == IDLE) || (state == DONE && out_ready);
   assign busy     = (state != IDLE);
   assign accept   = in_valid && in_ready && !flush;

   // Operand signedness: MULH/MULHSU/DIV/REM treat rs1 as signed, MULH/DIV/REM also rs2
   assign a_signed_in = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
   assign b_signed_in = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
   assign neg_a_in    = a_signed_in && operand_a[DATA_W-1];
   assign neg_b_in    = b_signed_in && operand_b[DATA_W-1];
   assign a_mag_in    = neg_a_in ? -operand_a : operand_a;
   assign b_mag_in    = neg_b_in ? -operand_b : operand_b;

   // Multiply: {acc,lo} holds the partial product with the multiplier shifting out of lo.
   // Divide: lo shifts the dividend into acc and collects quotient bits.
   assign mul_sum   = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : '0);
   assign div_shift = {acc, lo[DATA_W-1]};
   assign div_diff  = div_shift - {1'b0, opnd};
   assign div_ge    = !div_diff[DATA_W];

   always_comb begin
      prod_fix   = neg_res ? -{acc, lo} : {acc, lo};
      quo_fix    = div_zero ? '1 : (neg_res ? -lo : lo);
      rem_fix    = neg_rem ? -acc : acc;
      fix_result = '0;
      case (op_q)
         3'b000:                 fix_result = prod_fix[DATA_W-1:0];
         3'b001, 3'b010, 3'b011: fix_result = prod_fix[2*DATA_W-1:DATA_W];
         3'b100, 3'b101:         fix_result = quo_fix;
         default:                fix_result = rem_fix;
      endcase
   end

`ifdef MULDIV_EARLY_OUT_EN
   logic b_zero;
   logic sgn_ovf;
   always_comb begin
      b_zero       = (operand_b == '0);
      sgn_ovf      = ((op == 3'b100) || (op == 3'b110)) &&
                     (operand_a == {1'b1, {(DATA_W-1){1'b0}}}) && (operand_b == '1);
      early        = op[2] ? (b_zero || sgn_ovf) : ((operand_a == '0) || (operand_b == '0));
      early_result = '0;
      if (op[2]) begin
         if (b_zero)
            early_result = op[1] ? operand_a : '1;
         else
            early_result = op[1] ? '0 : operand_a;
      end
   end
`else
   assign early        = 1'b0;
   assign early_result = '0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         acc       <= '0;
         lo        <= '0;
         opnd      <= '0;
         op_q      <= '0;
         tag_q     <= '0;
         neg_res   <= 1'b0;
         neg_rem   <= 1'b0;
         div_zero  <= 1'b0;
         out_valid <= 1'b0;
         result    <= '0;
         out_tag   <= '0;
      end else if (flush) begin
         state     <= IDLE;
         cnt       <= '0;
         out_valid <= 1'b0;
         result    <= '0;
         out_tag   <= '0;
      end else begin
         case (state)
            CALC: begin
               if (op_q[2]) begin
                  acc <= div_ge ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0];
                  lo  <= {lo[DATA_W-2:0], div_ge};
               end else begin
                  acc <= mul_sum[DATA_W:1];
                  lo  <= {mul_sum[0], lo[DATA_W-1:1]};
               end
               cnt <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(DATA_W - 1))
                  state <= FIX;
            end
            FIX: begin
               result    <= fix_result;
               out_tag   <= tag_q;
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  result    <= '0;
                  out_tag   <= '0;
                  state     <= IDLE;
               end
            end
            default: ;
         endcase

         // A new request overrides whatever IDLE/DONE decided above
         if (accept) begin
            op_q     <= op;
            tag_q    <= in_tag;
            neg_res  <= neg_a_in ^ neg_b_in;
            neg_rem  <= neg_a_in;
            div_zero <= (operand_b == '0);
            cnt      <= '0;
            acc      <= '0;
            lo       <= op[2] ? a_mag_in : b_mag_in;
            opnd     <= op[2] ? b_mag_in : a_mag_in;
            if (early) begin
               state     <= DONE;
               out_valid <= 1'b1;
               result    <= early_result;
               out_tag   <= in_tag;
            end else begin
               state <= CALC;
            end
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (DATA_W=64): vector table plus hand-written
// sequences for DONE hold, back-to-back accept, flush and reset.
module tb_muldiv_unit;

   localparam int DATA_W = 64;
   localparam int TAG_W  = 5;
`ifdef MULDIV_EARLY_OUT_EN
   localparam bit EARLY_EN = 1'b1;
`else
   localparam bit EARLY_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        op;
   logic [DATA_W-1:0] operand_a;
   logic [DATA_W-1:0] operand_b;
   logic [TAG_W-1:0]  in_tag;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] result;
   logic [TAG_W-1:0]  out_tag;
   logic              busy;

   int checks = 0;
   int errors = 0;

   muldiv_unit #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .operand_a(operand_a), .operand_b(operand_b), .in_tag(in_tag), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .result(result), .out_tag(out_tag),
      .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]        op;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] exp;
      bit                early;
   } vec_t;

   vec_t vecs[20];

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   function automatic int expLat(input bit early);
      return (EARLY_EN && early) ? 1 : 66;
   endfunction

   // Waits up to 200 cycles for out_valid; returns the cycle count from the accept edge
   task automatic waitValid(output int lat);
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic applyStimulus(input int idx, input vec_t v);
      int    lat;
      string nm;
      nm = $sformatf("vec%0d", idx);
      checkOutput({nm, " in_ready"}, 64'(in_ready), 64'd1);
      in_valid  = 1'b1;
      op        = v.op;
      operand_a = v.a;
      operand_b = v.b;
      in_tag    = v.tag;
      @(posedge clk); #1;
      in_valid = 1'b0;
      waitValid(lat);
      checkOutput({nm, " out_valid"}, 64'(out_valid), 64'd1);
      checkOutput({nm, " result"}, result, v.exp);
      checkOutput({nm, " out_tag"}, 64'(out_tag), 64'(v.tag));
      checkOutput({nm, " latency"}, 64'(lat), 64'(expLat(v.early)));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checkOutput({nm, " cleared"}, {62'd0, out_valid, busy}, 64'd0);
      checkOutput({nm, " result zero"}, result, 64'd0);
   endtask

   initial begin
      int               lat;
      bit               seen;
      bit               stable;
      logic [DATA_W-1:0] held;

      vecs[0]  = '{3'b000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd3, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0};
      vecs[1]  = '{3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd4, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
      vecs[2]  = '{3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5, 64'd0, 1'b0};
      vecs[3]  = '{3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd6, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0};
      vecs[4]  = '{3'b110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
      vecs[5]  = '{3'b100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8, 64'h8000_0000_0000_0000, 1'b1};
      vecs[6]  = '{3'b110, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9, 64'd0, 1'b1};
      vecs[7]  = '{3'b101, 64'd5, 64'd0, 5'd10, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
      vecs[8]  = '{3'b111, 64'd5, 64'd0, 5'd11, 64'd5, 1'b1};
      vecs[9]  = '{3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 5'd12, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
      vecs[10] = '{3'b110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 5'd13, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1};
      vecs[11] = '{3'b010, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 5'd14, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
      vecs[12] = '{3'b011, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 5'd15, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0};
      vecs[13] = '{3'b000, 64'd0, 64'd5, 5'd16, 64'd0, 1'b1};
      vecs[14] = '{3'b001, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 5'd17, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
      vecs[15] = '{3'b101, 64'd100, 64'd7, 5'd18, 64'd14, 1'b0};
      vecs[16] = '{3'b111, 64'd100, 64'd7, 5'd19, 64'd2, 1'b0};
      vecs[17] = '{3'b100, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'd20, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0};
      vecs[18] = '{3'b110, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'd21, 64'd1, 1'b0};
      vecs[19] = '{3'b011, 64'h1_0000_0000, 64'h1_0000_0000, 5'd22, 64'd1, 1'b0};

      rst = 1'b1; in_valid = 1'b0; op = '0; operand_a = '0; operand_b = '0;
      in_tag = '0; flush = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      checkOutput("reset out_valid", 64'(out_valid), 64'd0);
      checkOutput("reset busy", 64'(busy), 64'd0);
      checkOutput("reset result", result, 64'd0);
      checkOutput("reset out_tag", 64'(out_tag), 64'd0);
      checkOutput("reset in_ready", 64'(in_ready), 64'd1);

      for (int i = 0; i < 20; i++)
         applyStimulus(i, vecs[i]);

      // DONE hold with out_ready low, then back-to-back accept
      in_valid = 1'b1; op = 3'b000; operand_a = 64'h10; operand_b = 64'h20; in_tag = 5'd9;
      @(posedge clk); #1;
      in_valid = 1'b0;
      waitValid(lat);
      checkOutput("hold first valid", 64'(out_valid), 64'd1);
      checkOutput("hold first result", result, 64'h200);
      held   = result;
      stable = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         if (result !== held || out_tag !== 5'd9 || out_valid !== 1'b1)
            stable = 1'b0;
      end
      checkOutput("hold stable", 64'(stable), 64'd1);
      in_valid = 1'b1; op = 3'b000; operand_a = 64'd3; operand_b = 64'd5; in_tag = 5'd10;
      out_ready = 1'b1;
      #1;
      checkOutput("b2b in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0;
      checkOutput("b2b accepted", {62'd0, busy, out_valid}, 64'd2);
      waitValid(lat);
      checkOutput("b2b latency", 64'(lat), 64'd66);
      checkOutput("b2b result", result, 64'd15);
      checkOutput("b2b out_tag", 64'(out_tag), 64'd10);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;

      // Flush at cycle 20 of CALC
      in_valid = 1'b1; op = 3'b000; operand_a = 64'd3; operand_b = 64'd5; in_tag = 5'd1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (19) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      checkOutput("flush in_ready", 64'(in_ready), 64'd1);
      checkOutput("flush busy", 64'(busy), 64'd0);
      seen = 1'b0;
      out_ready = 1'b1;
      repeat (80) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
      out_ready = 1'b0;
      checkOutput("flush no result", 64'(seen), 64'd0);

      // flush together with in_valid must not accept
      in_valid = 1'b1; flush = 1'b1; op = 3'b101; operand_a = 64'd9; operand_b = 64'd3;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      checkOutput("flush blocks accept", 64'(busy), 64'd0);

      // Reset mid-CALC, with flush and a new request asserted the same edge
      in_valid = 1'b1; op = 3'b101; operand_a = 64'd100; operand_b = 64'd7; in_tag = 5'd2;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) begin @(posedge clk); #1; end
      rst = 1'b1; flush = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
      checkOutput("rst outputs", {result, 59'(out_tag), out_valid, busy}, 64'd0);
      checkOutput("rst in_ready", 64'(in_ready), 64'd1);
      seen = 1'b0;
      out_ready = 1'b1;
      repeat (80) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
      out_ready = 1'b0;
      checkOutput("rst no result", 64'(seen), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 64: operand/result width; even, >= 8.
REQ-002 SHALL have parameter TAG_W, default 5: destination-register tag width.
REQ-003 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: request present.
REQ-006 SHALL have port in_ready, output, 1: unit can accept a request.
REQ-007 SHALL have port op, input, 3: RISC-V funct3 (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU).
REQ-008 SHALL have port operand_a, input, DATA_W: rs1 value / dividend.
REQ-009 SHALL have port operand_b, input, DATA_W: rs2 value / divisor.
REQ-010 SHALL have port in_tag, input, TAG_W: rd of the request.
REQ-011 SHALL have port flush, input, 1: abandon the in-flight operation.
REQ-012 SHALL have port out_valid, output, 1: result present.
REQ-013 SHALL have port out_ready, input, 1: consumer takes result.
REQ-014 SHALL have port result, output, DATA_W: operation result.
REQ-015 SHALL have port out_tag, output, TAG_W: in_tag of the completed request.
REQ-016 SHALL have port busy, output, 1: high in any state other than IDLE; drives pipeline stall.

Function
REQ-017 SHALL implement the FSM states IDLE, CALC, FIX and DONE.
REQ-018 Accept SHALL occur when in_valid && in_ready && !flush; operands, op and tag are latched on that edge.
REQ-019 in_ready SHALL equal (state==IDLE) || (state==DONE && out_ready).
REQ-020 Accept SHALL cause IDLE->CALC; DONE with out_ready and an accept SHALL go directly to CALC (back-to-back, no idle cycle).
REQ-021 CALC SHALL run a radix-2 iteration: one shift-add (multiply) or restoring shift-subtract (divide) per cycle, for exactly DATA_W cycles.
REQ-022 CALC SHALL use an iteration counter of $clog2(DATA_W)+1 bits; the CALC->FIX transition SHALL occur when the counter reaches DATA_W-1.
REQ-023 Iteration SHALL operate on magnitudes; FIX (1 cycle) SHALL apply sign correction and select the output, then go to DONE.
REQ-024 out_valid SHALL assert exactly DATA_W+2 cycles after the accept edge.
REQ-025 In DONE, out_valid SHALL be 1; result and out_tag SHALL stay stable until out_ready; DONE with out_ready and no accept SHALL go to IDLE.
REQ-026 MUL SHALL return the low DATA_W bits of the product; MULH, MULHSU and MULHU SHALL return the high DATA_W bits with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
REQ-027 Quotients SHALL truncate toward zero; the remainder sign SHALL follow the dividend.
REQ-028 For divisor 0: DIV/DIVU SHALL return all ones and REM/REMU SHALL return the dividend.
REQ-029 For signed overflow (most-negative / -1): DIV SHALL return the dividend and REM SHALL return 0.
REQ-030 flush SHALL, in any state, force IDLE on the next edge with out_valid=0 and no result emitted; flush together with in_valid SHALL cause no accept.
REQ-031 out_valid, result and out_tag SHALL be 0 whenever the state is not DONE.

Reset
REQ-032 rst SHALL force IDLE on the next edge with out_valid=0, busy=0, result=0, out_tag=0 and counter=0; in_ready SHALL be 1 on the first cycle after reset.
REQ-033 rst SHALL abort an operation in progress with no result emitted, and SHALL take priority over flush and accept.

Configuration
REQ-034 With macro MULDIV_EARLY_OUT_EN defined, divide-by-zero, signed overflow, and any multiply with a zero operand SHALL go IDLE->DONE, giving out_valid 1 cycle after accept, with the REQ-028/029 results (0 for a zero multiply).
REQ-035 Without MULDIV_EARLY_OUT_EN, every operation SHALL take the full DATA_W+2 cycle latency; results SHALL be identical either way.

Verification (DATA_W=64)
REQ-036 MUL 7 × 0xFFFFFFFFFFFFFFFD -> result 0xFFFFFFFFFFFFFFEB, out_valid at exactly cycle 66 after accept.
REQ-037 MULHU 0xFFFFFFFFFFFFFFFF × 0xFFFFFFFFFFFFFFFF -> 0xFFFFFFFFFFFFFFFE; MULH on the same operands -> 0.
REQ-038 DIV -7/2 -> 0xFFFFFFFFFFFFFFFD; REM -7/2 -> 0xFFFFFFFFFFFFFFFF; DIV 0x8000000000000000 / -1 -> 0x8000000000000000, and REM on the same operands -> 0.
REQ-039 DIVU 5/0 -> 0xFFFFFFFFFFFFFFFF; REMU 5/0 -> 5; latency 1 cycle with MULDIV_EARLY_OUT_EN, 66 cycles without.
REQ-040 Hold out_ready=0 for 10 cycles in DONE -> result, out_tag and out_valid stable; a new request with out_ready=1 -> accepted the same cycle, and the next out_valid follows 66 cycles later.
REQ-041 flush at cycle 20 of CALC -> out_valid never rises, in_ready=1 the next cycle; rst asserted mid-CALC -> all outputs 0 the next cycle.
